// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO FIFO register window: register offsets,
// STATUS/CTRL bit positions and the STATUS word builder.
package mmio_fifo_pkg;

    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_PEEK   = 3'd6;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UDF       = 3;
    localparam int ST_COUNT_LSB = 16;
    localparam int ST_DEPTH_LSB = 48;

    localparam int CTRL_FLUSH      = 0;
    localparam int CTRL_CLR_STICKY = 1;

    typedef enum logic [2:0] {
        REG_NONE   = 3'd0,
        REG_DATA   = 3'd1,
        REG_STATUS = 3'd2,
        REG_CTRL   = 3'd3,
        REG_PEEK   = 3'd4
    } reg_sel_e;

    // Maps a window-relative offset to a register; odd offsets select nothing.
    function automatic reg_sel_e decode_reg(input logic [2:0] off);
        reg_sel_e sel;
        case (off)
            OFF_DATA:   sel = REG_DATA;
            OFF_STATUS: sel = REG_STATUS;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_PEEK:   sel = REG_PEEK;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [63:0] status_word(
        input logic [15:0] depth,
        input logic [15:0] count,
        input logic        udf,
        input logic        ovf,
        input logic        full,
        input logic        empty
    );
        logic [63:0] w;
        w = 64'd0;
        w[ST_DEPTH_LSB +: 16] = depth;
        w[ST_COUNT_LSB +: 16] = count;
        w[ST_UDF]   = udf;
        w[ST_OVF]   = ovf;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo_csr_sync_fifo.sv
// Single-clock FIFO with guarded push/pop, flush and a combinational head.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s;
    logic              do_pop_s;
    logic              full_s;
    logic              empty_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == CW'(0));
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

    // Guarded transfer enables and next pointer/occupancy state.
    always_comb begin
        do_pop_s  = pop_i & ~empty_s;
        do_push_s = push_i & (~full_s | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mmio_fifo_csr.sv
// MMIO register window around a FIFO: DATA push/pop, STATUS, CTRL and PEEK,
// with sticky overflow/underflow flags and a registered read response.
module mmio_fifo_csr
    import mmio_fifo_pkg::*;
#(
    parameter  int          DATA_W    = 64,
    parameter  int          DEPTH     = 8,
    parameter  logic [15:0] BASE_ADDR = 16'h0020,
    parameter  int          TID_W     = 9,
    localparam int          CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mmio_wr_valid,
    input  logic             mmio_rd_valid,
    input  logic [15:0]      mmio_addr,
    input  logic [63:0]      mmio_wdata,
    input  logic [TID_W-1:0] mmio_tid,
    output logic             rsp_valid,
    output logic [TID_W-1:0] rsp_tid,
    output logic [63:0]      rsp_data,
    output logic [CW-1:0]    fifo_count
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    reg_sel_e          sel_s;
    logic              wr_data_s, wr_ctrl_s, rd_data_s, rd_hit_s;
    logic              flush_s, clr_s, ovf_set_s, udf_set_s;
    logic [DATA_W-1:0] head_s;
    logic [63:0]       head_ext_s;
    logic [CW-1:0]     count_s;
    logic              full_s, empty_s;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
    logic [63:0]       rsp_data_q, rsp_data_d;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_data_s),
        .pop_i   (rd_data_s),
        .flush_i (flush_s),
        .din_i   (mmio_wdata[DATA_W-1:0]),
        .dout_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Address decode; BASE_ADDR is 8-aligned so the window is one 8-word block.
    always_comb begin
        if (mmio_addr[15:3] == BASE_ADDR[15:3]) begin
            sel_s = decode_reg(mmio_addr[2:0]);
        end else begin
            sel_s = REG_NONE;
        end
        wr_data_s = mmio_wr_valid & (sel_s == REG_DATA);
        wr_ctrl_s = mmio_wr_valid & (sel_s == REG_CTRL);
        rd_data_s = mmio_rd_valid & (sel_s == REG_DATA);
        rd_hit_s  = mmio_rd_valid & (sel_s != REG_NONE);
        flush_s   = wr_ctrl_s & mmio_wdata[CTRL_FLUSH];
        clr_s     = wr_ctrl_s & mmio_wdata[CTRL_CLR_STICKY];
        // A full FIFO with a same-cycle pop has room, so that push is not an overflow.
        ovf_set_s = wr_data_s & full_s & ~rd_data_s;
        udf_set_s = rd_data_s & empty_s;
    end

    // Sticky flag next state: a same-cycle set beats a clear.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (udf_set_s) begin
            udf_d = 1'b1;
        end else if (clr_s) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // Read data selection from pre-update state.
    always_comb begin
        head_ext_s = 64'd0;
        head_ext_s[DATA_W-1:0] = head_s;
        rsp_data_d = rsp_data_q;
        rsp_tid_d  = rsp_tid_q;
        rsp_valid_d = rd_hit_s;
        if (rd_hit_s) begin
            rsp_tid_d = mmio_tid;
            case (sel_s)
                REG_DATA, REG_PEEK: rsp_data_d = empty_s ? 64'd0 : head_ext_s;
                REG_STATUS: rsp_data_d = status_word(DEPTH16, 16'(count_s), udf_q,
                                                     ovf_q, full_s, empty_s);
                default:    rsp_data_d = 64'd0;
            endcase
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_tid_d  = rsp_tid_q;
        end
    end

    // Sticky flags and the registered read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= TID_W'(0);
            rsp_data_q  <= 64'd0;
        end else begin
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_tid    = rsp_tid_q;
    assign rsp_data   = rsp_data_q;
    assign fifo_count = count_s;

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Directed and randomized bench for mmio_fifo_csr, checked against a queue model.
module tb_mmio_fifo_csr;

    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'h0020;

    logic        clk;
    logic        rst;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [63:0] mmio_wdata;
    logic [8:0]  mmio_tid;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  fifo_count;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] mq[$];
    bit          m_ovf;
    bit          m_udf;

    mmio_fifo_csr #(
        .DATA_W    (64),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .TID_W     (9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_wdata    (mmio_wdata),
        .mmio_tid      (mmio_tid),
        .rsp_valid     (rsp_valid),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] s;
        s = 64'(DEPTH) * 64'h0001_0000_0000_0000 + 64'(mq.size()) * 64'h1_0000;
        s = s + (m_udf ? 64'd8 : 64'd0) + (m_ovf ? 64'd4 : 64'd0);
        s = s + ((mq.size() == DEPTH) ? 64'd2 : 64'd0) + ((mq.size() == 0) ? 64'd1 : 64'd0);
        return s;
    endfunction

    // One MMIO cycle: predict from the model, drive, then check one edge later.
    task automatic op(input logic wr, input logic rd, input logic [15:0] addr,
                      input logic [63:0] wd, input logic [8:0] tid);
        bit          hit;
        int          off;
        logic        exp_v;
        logic [63:0] exp_d;
        hit = (addr >= BASE) && (addr <= BASE + 16'd6) && (addr % 2 == 0);
        off = int'(addr) - int'(BASE);
        exp_v = rd && hit;
        exp_d = 64'd0;
        if (hit && (off == 0 || off == 6) && mq.size() > 0) exp_d = mq[0];
        if (hit && off == 2) exp_d = model_status();
        if (rd && hit && off == 0) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_udf = 1'b1;
        end
        if (wr && hit && off == 0) begin
            if (mq.size() < DEPTH) mq.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (wr && hit && off == 4) begin
            if (wd[1]) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wd[0]) mq.delete();
        end
        @(negedge clk);
        mmio_wr_valid = wr;
        mmio_rd_valid = rd;
        mmio_addr     = addr;
        mmio_wdata    = wd;
        mmio_tid      = tid;
        @(posedge clk);
        #1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            chk("rsp_data", rsp_data, exp_d);
            chk("rsp_tid", 64'(rsp_tid), 64'(tid));
        end
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    endtask

    initial begin
        rst = 1'b1;
        mmio_wr_valid = 1'b0;
        mmio_rd_valid = 1'b0;
        mmio_addr  = 16'h0000;
        mmio_wdata = 64'd0;
        mmio_tid   = 9'd0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;

        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'h1A5);
        chk("status_after_reset", rsp_data, 64'h0008_0000_0000_0001);
        chk("status_tid", 64'(rsp_tid), 64'h1A5);

        op(1'b1, 1'b0, BASE, 64'h11, 9'd0);
        op(1'b1, 1'b0, BASE, 64'h22, 9'd0);
        op(1'b1, 1'b0, BASE, 64'h33, 9'd0);
        op(1'b0, 1'b1, BASE + 16'd6, 64'd0, 9'd1);
        chk("peek_head", rsp_data, 64'h11);
        op(1'b0, 1'b1, BASE, 64'd0, 9'd2);
        chk("pop0", rsp_data, 64'h11);
        op(1'b0, 1'b1, BASE, 64'd0, 9'd3);
        chk("pop1", rsp_data, 64'h22);
        op(1'b0, 1'b1, BASE, 64'd0, 9'd4);
        chk("pop2", rsp_data, 64'h33);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd5);
        chk("status_drained", rsp_data, 64'h0008_0000_0000_0001);

        for (int i = 0; i < 9; i++) op(1'b1, 1'b0, BASE, 64'h100 + 64'(i), 9'd0);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd6);
        chk("status_overflow", rsp_data, 64'h0008_0000_0008_0006);
        for (int i = 0; i < 8; i++) begin
            op(1'b0, 1'b1, BASE, 64'd0, 9'(i));
            chk("wrap_pop", rsp_data, 64'h100 + 64'(i));
        end

        op(1'b0, 1'b1, BASE, 64'd0, 9'd7);
        chk("underflow_data", rsp_data, 64'd0);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd8);
        chk("status_stickies", rsp_data, 64'h0008_0000_0000_000D);
        op(1'b1, 1'b0, BASE + 16'd4, 64'h2, 9'd0);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd9);
        chk("status_cleared", rsp_data, 64'h0008_0000_0000_0001);

        for (int i = 0; i < 8; i++) op(1'b1, 1'b0, BASE, 64'h200 + 64'(i), 9'd0);
        op(1'b1, 1'b1, BASE, 64'hAA, 9'd10);
        chk("full_pushpop_data", rsp_data, 64'h200);
        chk("full_pushpop_count", 64'(fifo_count), 64'd8);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd11);
        chk("full_pushpop_status", rsp_data, 64'h0008_0000_0008_0002);
        for (int i = 0; i < 8; i++) op(1'b0, 1'b1, BASE, 64'd0, 9'(i));
        chk("drain_last", rsp_data, 64'hAA);

        op(1'b1, 1'b1, BASE, 64'h5A, 9'd12);
        chk("empty_pushpop_data", rsp_data, 64'd0);
        op(1'b1, 1'b0, BASE + 16'd4, 64'h3, 9'd0);

        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, BASE, 64'h300 + 64'(i), 9'd0);
        op(1'b1, 1'b0, BASE + 16'd4, 64'h1, 9'd0);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd13);
        chk("status_flushed", rsp_data, 64'h0008_0000_0000_0001);
        op(1'b0, 1'b1, 16'h0030, 64'd0, 9'd14);
        op(1'b0, 1'b1, BASE + 16'd1, 64'd0, 9'd15);
        op(1'b0, 1'b1, BASE + 16'd4, 64'd0, 9'd16);
        chk("ctrl_read_zero", rsp_data, 64'd0);

        op(1'b1, 1'b0, BASE, 64'h55, 9'd0);
        op(1'b1, 1'b0, BASE, 64'h66, 9'd0);
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd17);
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        chk("reset_cancels_rsp", 64'(rsp_valid), 64'd0);
        chk("reset_clears_count", 64'(fifo_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        op(1'b0, 1'b1, BASE + 16'd2, 64'd0, 9'd18);
        chk("status_post_reset", rsp_data, 64'h0008_0000_0000_0001);

        for (int n = 0; n < 600; n++) begin
            int          r;
            logic [15:0] a;
            r = int'($urandom_range(0, 15));
            if (r <= 6)       a = BASE;
            else if (r <= 9)  a = BASE + 16'd2;
            else if (r == 10) a = BASE + 16'd4;
            else if (r == 11) a = BASE + 16'd6;
            else              a = BASE + 16'($urandom_range(0, 15));
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
               {$urandom, $urandom}, 9'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
